// File: rtl/dispatch.sv
// Receiving end of the executer-to-dispatch interface: store-and-forward packet buffer
// that steers each complete packet to the up-CPU path, the down-port path, or drops it.
module dispatch #(
    parameter int DFIFO_AW  = 8,
    parameter int ALF_LEVEL = 160,
    parameter int DESC_AW   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         exe2disp_direction_req,
    input  logic         exe2disp_direction,
    input  logic         exe2disp_data_wr,
    input  logic [133:0] exe2disp_data,
    input  logic         exe2disp_valid_wr,
    input  logic         exe2disp_valid,
    output logic         disp2exe_alf,
    output logic         disp2up_data_wr,
    output logic [133:0] disp2up_data,
    output logic         disp2up_valid_wr,
    output logic         disp2up_valid,
    input  logic         up2disp_alf,
    output logic         disp2down_data_wr,
    output logic [133:0] disp2down_data,
    output logic         disp2down_valid_wr,
    output logic         disp2down_valid,
    input  logic         down2disp_alf,
    output logic [31:0]  up_pkt_cnt,
    output logic [31:0]  down_pkt_cnt,
    output logic [31:0]  drop_pkt_cnt,
    output logic         err_overflow
);

    localparam int DDEPTH = 1 << DFIFO_AW;
    localparam int QDEPTH = 1 << DESC_AW;
    localparam logic [DFIFO_AW:0] DCNT_FULL = (DFIFO_AW + 1)'(DDEPTH);
    localparam logic [DFIFO_AW:0] DCNT_ALF  = (DFIFO_AW + 1)'(ALF_LEVEL);
    localparam logic [DESC_AW:0]  QCNT_FULL = (DESC_AW + 1)'(QDEPTH);
    localparam logic [DESC_AW:0]  QCNT_ALF  = (DESC_AW + 1)'(QDEPTH - 2);
    localparam logic [1:0] SITE_HEAD = 2'b01;
    localparam logic [1:0] SITE_TAIL = 2'b10;

    typedef enum logic [1:0] {IDLE_S, UP_S, DOWN_S, DROP_S} state_t;

    state_t              state_r;
    logic                in_pkt_r, head_dir_r, head_req_r;
    logic [133:0]        dmem_r [DDEPTH];
    logic [DFIFO_AW-1:0] dwr_ptr_r, drd_ptr_r;
    logic [DFIFO_AW:0]   dcnt_r;
    logic [1:0]          qmem_r [QDEPTH];
    logic [DESC_AW-1:0]  qwr_ptr_r, qrd_ptr_r;
    logic [DESC_AW:0]    qcnt_r;
    logic                alf_r, err_r;
    logic                up_wr_r, up_vwr_r, down_wr_r, down_vwr_r;
    logic [133:0]        up_data_r, down_data_r;
    logic [31:0]         up_cnt_r, down_cnt_r, drop_cnt_r;

    logic         is_head_s, accept_s, pkt_end_s, dfull_s, dempty_s, dwr_s, drd_s;
    logic         qfull_s, qempty_s, qpush_s, qpop_s, keep_s, dir_s, qkeep_s, qdir_s;
    logic [133:0] rd_flit_s;
    logic         rd_tail_s;

    // Input acceptance, descriptor formation and FIFO read/write enables
    always_comb begin
        // A lone tail arriving outside a packet is a single-flit packet only while the
        // executer holds a rule; otherwise it is an orphan left over from a reset.
        is_head_s = exe2disp_data_wr &&
                    ((exe2disp_data[133:132] == SITE_HEAD) ||
                     (!in_pkt_r && exe2disp_valid_wr && exe2disp_direction_req));
        accept_s  = exe2disp_data_wr && (in_pkt_r || is_head_s);
        pkt_end_s = exe2disp_valid_wr && (in_pkt_r || is_head_s);
        dfull_s   = (dcnt_r == DCNT_FULL);
        dempty_s  = (dcnt_r == '0);
        qfull_s   = (qcnt_r == QCNT_FULL);
        qempty_s  = (qcnt_r == '0);
        dwr_s     = accept_s && !dfull_s;
        qpush_s   = pkt_end_s && !qfull_s;
        keep_s    = exe2disp_valid && (is_head_s ? exe2disp_direction_req : head_req_r);
        dir_s     = is_head_s ? exe2disp_direction : head_dir_r;
        qkeep_s   = qmem_r[qrd_ptr_r][1];
        qdir_s    = qmem_r[qrd_ptr_r][0];
        rd_flit_s = dmem_r[drd_ptr_r];
        rd_tail_s = (rd_flit_s[133:132] == SITE_TAIL);
        qpop_s    = (state_r == IDLE_S) && !qempty_s &&
                    (!qkeep_s || (qdir_s ? !down2disp_alf : !up2disp_alf));
        drd_s     = (state_r != IDLE_S) && !dempty_s;
    end

    // Storage arrays: cleared logically through their pointers, contents never reset
    always_ff @(posedge clk) begin
        if (dwr_s) dmem_r[dwr_ptr_r] <= exe2disp_data;
        if (qpush_s) qmem_r[qwr_ptr_r] <= {keep_s, dir_s};
    end

    // Input packet tracking, FIFO pointers/occupancy, backpressure and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_pkt_r   <= 1'b0;
            head_dir_r <= 1'b0;
            head_req_r <= 1'b0;
            dwr_ptr_r  <= '0;
            drd_ptr_r  <= '0;
            dcnt_r     <= '0;
            qwr_ptr_r  <= '0;
            qrd_ptr_r  <= '0;
            qcnt_r     <= '0;
            alf_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            if (pkt_end_s) in_pkt_r <= 1'b0;
            else if (is_head_s) in_pkt_r <= 1'b1;
            if (is_head_s) begin
                head_dir_r <= exe2disp_direction;
                head_req_r <= exe2disp_direction_req;
            end
            if (dwr_s) dwr_ptr_r <= dwr_ptr_r + 1'b1;
            if (drd_s) drd_ptr_r <= drd_ptr_r + 1'b1;
            case ({dwr_s, drd_s})
                2'b10:   dcnt_r <= dcnt_r + 1'b1;
                2'b01:   dcnt_r <= dcnt_r - 1'b1;
                default: dcnt_r <= dcnt_r;
            endcase
            if (qpush_s) qwr_ptr_r <= qwr_ptr_r + 1'b1;
            if (qpop_s) qrd_ptr_r <= qrd_ptr_r + 1'b1;
            case ({qpush_s, qpop_s})
                2'b10:   qcnt_r <= qcnt_r + 1'b1;
                2'b01:   qcnt_r <= qcnt_r - 1'b1;
                default: qcnt_r <= qcnt_r;
            endcase
            alf_r <= (dcnt_r >= DCNT_ALF) || (qcnt_r >= QCNT_ALF);
            err_r <= err_r || (accept_s && dfull_s);
        end
    end

    // Output FSM: one descriptor per packet, one flit per cycle, registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE_S;
            up_wr_r     <= 1'b0;
            up_vwr_r    <= 1'b0;
            down_wr_r   <= 1'b0;
            down_vwr_r  <= 1'b0;
            up_data_r   <= '0;
            down_data_r <= '0;
            up_cnt_r    <= '0;
            down_cnt_r  <= '0;
            drop_cnt_r  <= '0;
        end else begin
            up_wr_r    <= 1'b0;
            up_vwr_r   <= 1'b0;
            down_wr_r  <= 1'b0;
            down_vwr_r <= 1'b0;
            case (state_r)
                IDLE_S: begin
                    if (qpop_s) state_r <= !qkeep_s ? DROP_S : (qdir_s ? DOWN_S : UP_S);
                    else state_r <= IDLE_S;
                end
                UP_S: begin
                    if (drd_s) begin
                        up_wr_r   <= 1'b1;
                        up_data_r <= rd_flit_s;
                        if (rd_tail_s) begin
                            up_vwr_r <= 1'b1;
                            up_cnt_r <= up_cnt_r + 32'd1;
                            state_r  <= IDLE_S;
                        end
                    end
                end
                DOWN_S: begin
                    if (drd_s) begin
                        down_wr_r   <= 1'b1;
                        down_data_r <= rd_flit_s;
                        if (rd_tail_s) begin
                            down_vwr_r <= 1'b1;
                            down_cnt_r <= down_cnt_r + 32'd1;
                            state_r    <= IDLE_S;
                        end
                    end
                end
                DROP_S: begin
                    if (drd_s && rd_tail_s) begin
                        drop_cnt_r <= drop_cnt_r + 32'd1;
                        state_r    <= IDLE_S;
                    end
                end
                default: state_r <= IDLE_S;
            endcase
        end
    end

    assign disp2exe_alf       = alf_r;
    assign err_overflow       = err_r;
    assign disp2up_data_wr    = up_wr_r;
    assign disp2up_data       = up_data_r;
    assign disp2up_valid_wr   = up_vwr_r;
    assign disp2up_valid      = up_vwr_r;
    assign disp2down_data_wr  = down_wr_r;
    assign disp2down_data     = down_data_r;
    assign disp2down_valid_wr = down_vwr_r;
    assign disp2down_valid    = down_vwr_r;
    assign up_pkt_cnt         = up_cnt_r;
    assign down_pkt_cnt       = down_cnt_r;
    assign drop_pkt_cnt       = drop_cnt_r;

endmodule

// File: tb/tb_dispatch.sv
// Directed bench for dispatch: routing, drop, head-of-line wait, backpressure,
// overflow and mid-packet reset, with hand-computed expected flits and counters.
module tb_dispatch;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         exe2disp_direction_req = 1'b0, exe2disp_direction = 1'b0;
    logic         exe2disp_data_wr = 1'b0, exe2disp_valid_wr = 1'b0, exe2disp_valid = 1'b0;
    logic [133:0] exe2disp_data = '0;
    logic         up2disp_alf = 1'b0, down2disp_alf = 1'b0;
    logic         disp2exe_alf, err_overflow;
    logic         disp2up_data_wr, disp2up_valid_wr, disp2up_valid;
    logic         disp2down_data_wr, disp2down_valid_wr, disp2down_valid;
    logic [133:0] disp2up_data, disp2down_data;
    logic [31:0]  up_pkt_cnt, down_pkt_cnt, drop_pkt_cnt;

    dispatch dut (
        .clk(clk), .rst_n(rst_n),
        .exe2disp_direction_req(exe2disp_direction_req), .exe2disp_direction(exe2disp_direction),
        .exe2disp_data_wr(exe2disp_data_wr), .exe2disp_data(exe2disp_data),
        .exe2disp_valid_wr(exe2disp_valid_wr), .exe2disp_valid(exe2disp_valid),
        .disp2exe_alf(disp2exe_alf),
        .disp2up_data_wr(disp2up_data_wr), .disp2up_data(disp2up_data),
        .disp2up_valid_wr(disp2up_valid_wr), .disp2up_valid(disp2up_valid),
        .up2disp_alf(up2disp_alf),
        .disp2down_data_wr(disp2down_data_wr), .disp2down_data(disp2down_data),
        .disp2down_valid_wr(disp2down_valid_wr), .disp2down_valid(disp2down_valid),
        .down2disp_alf(down2disp_alf),
        .up_pkt_cnt(up_pkt_cnt), .down_pkt_cnt(down_pkt_cnt), .drop_pkt_cnt(drop_pkt_cnt),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int t_tail;
    logic [133:0] up_q[$], dn_q[$];
    logic [1:0]   upv_q[$], dnv_q[$];
    int           upc_q[$], dnc_q[$];

    // Edge counter used for latency and ordering checks
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampling on the inactive edge
    always @(negedge clk) begin
        if (disp2up_data_wr) begin
            up_q.push_back(disp2up_data);
            upv_q.push_back({disp2up_valid_wr, disp2up_valid});
            upc_q.push_back(cyc);
        end
        if (disp2down_data_wr) begin
            dn_q.push_back(disp2down_data);
            dnv_q.push_back({disp2down_valid_wr, disp2down_valid});
            dnc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [133:0] mk(input logic [1:0] site, input logic [7:0] tag);
        return {site, tag[3:0], 120'h0, tag};
    endfunction

    function automatic logic [133:0] up_at(input int i);
        if (i < up_q.size()) return up_q[i];
        return '1;
    endfunction
    function automatic logic [133:0] dn_at(input int i);
        if (i < dn_q.size()) return dn_q[i];
        return '1;
    endfunction
    function automatic logic [1:0] upv_at(input int i);
        if (i < upv_q.size()) return upv_q[i];
        return 2'b01;
    endfunction
    function automatic logic [1:0] dnv_at(input int i);
        if (i < dnv_q.size()) return dnv_q[i];
        return 2'b01;
    endfunction

    task automatic flit(input logic [1:0] site, input logic [7:0] tag, input logic req,
                        input logic dir, input logic vwr, input logic v);
        @(negedge clk);
        exe2disp_data_wr       = 1'b1;
        exe2disp_data          = mk(site, tag);
        exe2disp_direction_req = req;
        exe2disp_direction     = dir;
        exe2disp_valid_wr      = vwr;
        exe2disp_valid         = v;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            exe2disp_data_wr  = 1'b0;
            exe2disp_valid_wr = 1'b0;
            exe2disp_valid    = 1'b0;
        end
    endtask

    task automatic clrq();
        up_q.delete(); upv_q.delete(); upc_q.delete();
        dn_q.delete(); dnv_q.delete(); dnc_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        check("rst_alf", 134'(disp2exe_alf), 134'd0);
        check("rst_up_wr", 134'(disp2up_data_wr), 134'd0);
        check("rst_dn_wr", 134'(disp2down_data_wr), 134'd0);
        check("rst_cnts", 134'({up_pkt_cnt, down_pkt_cnt, drop_pkt_cnt}), 134'd0);
        check("rst_err", 134'(err_overflow), 134'd0);

        // 3-flit up packet; direction changes after the head must be ignored
        clrq();
        flit(2'b01, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        flit(2'b11, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0);
        flit(2'b10, 8'h13, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1);
        t_tail = cyc;
        idle(9);
        check("t1_up_n", 134'(up_q.size()), 134'd3);
        check("t1_up0", up_at(0), mk(2'b01, 8'h11));
        check("t1_up1", up_at(1), mk(2'b11, 8'h12));
        check("t1_up2", up_at(2), mk(2'b10, 8'h13));
        check("t1_v0", 134'(upv_at(0)), 134'd0);
        check("t1_v1", 134'(upv_at(1)), 134'd0);
        check("t1_v2", 134'(upv_at(2)), 134'd3);
        check("t1_latency", 134'(upc_q.size() > 0 ? upc_q[0] - t_tail : -1), 134'd2);
        check("t1_dn_n", 134'(dn_q.size()), 134'd0);
        check("t1_upcnt", 134'(up_pkt_cnt), 134'd1);

        // single-flit down packet
        clrq();
        flit(2'b10, 8'h21, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(10);
        check("t2_dn_n", 134'(dn_q.size()), 134'd1);
        check("t2_dn0", dn_at(0), mk(2'b10, 8'h21));
        check("t2_v0", 134'(dnv_at(0)), 134'd3);
        check("t2_up_n", 134'(up_q.size()), 134'd0);
        check("t2_dncnt", 134'(down_pkt_cnt), 134'd1);

        // dropped packet followed by a down packet
        clrq();
        flit(2'b01, 8'h31, 1'b1, 1'b0, 1'b0, 1'b0);
        flit(2'b10, 8'h32, 1'b1, 1'b0, 1'b1, 1'b0);
        flit(2'b01, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
        flit(2'b10, 8'h34, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(15);
        check("t3_up_n", 134'(up_q.size()), 134'd0);
        check("t3_dn_n", 134'(dn_q.size()), 134'd2);
        check("t3_dn0", dn_at(0), mk(2'b01, 8'h33));
        check("t3_dn1", dn_at(1), mk(2'b10, 8'h34));
        check("t3_v1", 134'(dnv_at(1)), 134'd3);
        check("t3_drop", 134'(drop_pkt_cnt), 134'd1);
        check("t3_dncnt", 134'(down_pkt_cnt), 134'd2);

        // head-of-line wait on up path blocks the queued down packet too
        clrq();
        up2disp_alf = 1'b1;
        flit(2'b01, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0);
        flit(2'b10, 8'h42, 1'b1, 1'b0, 1'b1, 1'b1);
        flit(2'b01, 8'h43, 1'b1, 1'b1, 1'b0, 1'b0);
        flit(2'b10, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(10);
        check("t4_hold_up", 134'(up_q.size()), 134'd0);
        check("t4_hold_dn", 134'(dn_q.size()), 134'd0);
        up2disp_alf = 1'b0;
        idle(15);
        check("t4_up0", up_at(0), mk(2'b01, 8'h41));
        check("t4_up1", up_at(1), mk(2'b10, 8'h42));
        check("t4_dn0", dn_at(0), mk(2'b01, 8'h43));
        check("t4_dn1", dn_at(1), mk(2'b10, 8'h44));
        check("t4_order", 134'((upc_q.size() > 1 && dnc_q.size() > 0) ? (upc_q[1] < dnc_q[0]) : 1'b0), 134'd1);
        check("t4_cnts", 134'({up_pkt_cnt, down_pkt_cnt}), 134'({32'd2, 32'd3}));

        // almost-full threshold and overflow on one long unterminated packet
        clrq();
        flit(2'b01, 8'h50, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 160; i++) flit(2'b11, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("t5_alf_lag", 134'(disp2exe_alf), 134'd0);
        idle(1);
        check("t5_alf_set", 134'(disp2exe_alf), 134'd1);
        for (int i = 160; i < 256; i++) flit(2'b11, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("t5_full_noerr", 134'(err_overflow), 134'd0);
        flit(2'b11, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0);
        flit(2'b11, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("t5_err", 134'(err_overflow), 134'd1);
        idle(3);
        check("t5_err_sticky", 134'(err_overflow), 134'd1);
        check("t5_no_out", 134'(up_q.size() + dn_q.size()), 134'd0);

        // reset, then reset again mid-packet with orphan flits afterwards
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("t6_rst_err", 134'(err_overflow), 134'd0);
        check("t6_rst_alf", 134'(disp2exe_alf), 134'd0);
        clrq();
        flit(2'b01, 8'h61, 1'b1, 1'b0, 1'b0, 1'b0);
        flit(2'b11, 8'h62, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        exe2disp_data_wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        flit(2'b11, 8'h63, 1'b0, 1'b0, 1'b0, 1'b0);
        flit(2'b10, 8'h64, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(10);
        check("t6_orphan_out", 134'(up_q.size() + dn_q.size()), 134'd0);
        check("t6_cnts", 134'({up_pkt_cnt, down_pkt_cnt, drop_pkt_cnt}), 134'd0);
        flit(2'b01, 8'h65, 1'b1, 1'b0, 1'b0, 1'b0);
        flit(2'b10, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(10);
        check("t6_up_n", 134'(up_q.size()), 134'd2);
        check("t6_up0", up_at(0), mk(2'b01, 8'h65));
        check("t6_up1", up_at(1), mk(2'b10, 8'h66));
        check("t6_upcnt", 134'(up_pkt_cnt), 134'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
